// File: rtl/multicycle_ctrl_pkg.sv
// Shared constants for the multicycle RV32I control path: opcodes, FSM
// state encoding, ALU operation codes and an opcode classifier.
package multicycle_ctrl_pkg;

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_ITYPE  = 7'b0010011;
  localparam logic [6:0] OP_RTYPE  = 7'b0110011;
  localparam logic [6:0] OP_BTYPE  = 7'b1100011;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;

  localparam logic [2:0] ST_FETCH  = 3'd0;
  localparam logic [2:0] ST_DECODE = 3'd1;
  localparam logic [2:0] ST_EXEC   = 3'd2;
  localparam logic [2:0] ST_MEM    = 3'd3;
  localparam logic [2:0] ST_WB     = 3'd4;
  localparam logic [2:0] ST_TRAP   = 3'd5;

  localparam logic [3:0] ALU_ADD   = 4'b0000;
  localparam logic [3:0] ALU_SUB   = 4'b1000;

  typedef enum logic [2:0] {
    OPC_LOAD, OPC_STORE, OPC_ITYPE, OPC_RTYPE, OPC_BTYPE, OPC_AUIPC, OPC_ILLEGAL
  } op_class_e;

  // Map a raw opcode onto the instruction class the FSM sequences on.
  function automatic op_class_e classify(input logic [6:0] op);
    op_class_e cls;
    case (op)
      OP_LOAD:  cls = OPC_LOAD;
      OP_STORE: cls = OPC_STORE;
      OP_ITYPE: cls = OPC_ITYPE;
      OP_RTYPE: cls = OPC_RTYPE;
      OP_BTYPE: cls = OPC_BTYPE;
      OP_AUIPC: cls = OPC_AUIPC;
      default:  cls = OPC_ILLEGAL;
    endcase
    return cls;
  endfunction

endpackage

// File: rtl/multicycle_ctrl_if.sv
// Memory request/ready handshake bundle between the controller and the
// instruction/data memories.
interface multicycle_ctrl_if;
  logic imem_req;
  logic imem_ready;
  logic dmem_req;
  logic dmem_we;
  logic dmem_ready;

  modport master (output imem_req, dmem_req, dmem_we, input imem_ready, dmem_ready);
  modport slave  (input imem_req, dmem_req, dmem_we, output imem_ready, dmem_ready);
endinterface

// File: rtl/multicycle_ctrl_mem_wait_timer.sv
// Wait-cycle watchdog shared by the instruction and data ports. Only one
// request is ever outstanding, so a single counter serves both.
module multicycle_ctrl_mem_wait_timer #(
  parameter int unsigned TIMEOUT = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic waiting,
  input  logic ready,
  output logic expired
);
  localparam int unsigned CW = $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0] LAST_WAIT = CW'(TIMEOUT - 1);

  logic [CW-1:0] cnt_r;

  // Count stalled cycles of the current request; restart on every state change.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_r <= {CW{1'b0}};
    end else if (clear) begin
      cnt_r <= {CW{1'b0}};
    end else if (waiting && !ready) begin
      cnt_r <= cnt_r + CW'(1);
    end else begin
      cnt_r <= cnt_r;
    end
  end

  // A ready in the final allowed cycle still completes the access.
  assign expired = waiting & ~ready & (cnt_r == LAST_WAIT);
endmodule

// File: rtl/multicycle_ctrl.sv
// Main control FSM of the multicycle RV32I core: sequences fetch, decode,
// execute, memory and writeback, and traps on illegal opcodes or memory
// timeouts.
module multicycle_ctrl
  import multicycle_ctrl_pkg::*;
#(
  parameter int unsigned TIMEOUT = 16,
  parameter int unsigned CNT_W   = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [6:0]            opcode,
  input  logic [2:0]            func3,
  input  logic                  func7,
  input  logic [4:0]            rd,
  input  logic                  branch_taken,
  multicycle_ctrl_if.master     mem,
  output logic                  ir_we,
  output logic                  pc_we,
  output logic                  pc_src,
  output logic                  reg_we,
  output logic                  alu_src_b,
  output logic                  alu_src_a,
  output logic [3:0]            alu_op,
  output logic                  wb_sel,
  output logic                  halt,
  output logic                  bus_err,
  output logic [CNT_W-1:0]      retired
);
  logic [2:0]       state_r, state_next_s;
  logic             halt_r, bus_err_r;
  logic [CNT_W-1:0] retired_r;
  logic             imem_req_s, dmem_req_s, dmem_we_s;
  logic             retire_s, timeout_s, expired_s;
  op_class_e        cls_s;

  assign cls_s = classify(opcode);

  multicycle_ctrl_mem_wait_timer #(.TIMEOUT(TIMEOUT)) u_wait_timer (
    .clk     (clk),
    .rst     (rst),
    .clear   (state_next_s != state_r),
    .waiting (imem_req_s | dmem_req_s),
    .ready   ((state_r == ST_FETCH) ? mem.imem_ready : mem.dmem_ready),
    .expired (expired_s)
  );

  // Next-state and per-state control decode; outputs depend only on state and inputs.
  always_comb begin
    state_next_s = state_r;
    imem_req_s   = 1'b0;
    dmem_req_s   = 1'b0;
    dmem_we_s    = 1'b0;
    ir_we        = 1'b0;
    pc_we        = 1'b0;
    pc_src       = 1'b0;
    reg_we       = 1'b0;
    alu_src_a    = 1'b0;
    alu_src_b    = 1'b0;
    alu_op       = ALU_ADD;
    wb_sel       = 1'b0;
    retire_s     = 1'b0;
    timeout_s    = 1'b0;
    case (state_r)
      ST_FETCH: begin
        imem_req_s = 1'b1;
        if (mem.imem_ready) begin
          ir_we        = 1'b1;
          state_next_s = ST_DECODE;
        end else if (expired_s) begin
          timeout_s    = 1'b1;
          state_next_s = ST_TRAP;
        end else begin
          state_next_s = ST_FETCH;
        end
      end
      ST_DECODE: begin
        if (cls_s == OPC_ILLEGAL) begin
          state_next_s = ST_TRAP;
        end else begin
          state_next_s = ST_EXEC;
        end
      end
      ST_EXEC: begin
        case (cls_s)
          OPC_RTYPE: begin
            alu_op       = {func7, func3};
            state_next_s = ST_WB;
          end
          OPC_ITYPE: begin
            alu_src_b    = 1'b1;
            alu_op       = {func7 & (func3 == 3'b101), func3};
            state_next_s = ST_WB;
          end
          OPC_AUIPC: begin
            alu_src_a    = 1'b1;
            alu_src_b    = 1'b1;
            state_next_s = ST_WB;
          end
          OPC_LOAD, OPC_STORE: begin
            alu_src_b    = 1'b1;
            state_next_s = ST_MEM;
          end
          OPC_BTYPE: begin
            alu_op       = ALU_SUB | {1'b0, func3};
            pc_we        = 1'b1;
            pc_src       = branch_taken;
            retire_s     = 1'b1;
            state_next_s = ST_FETCH;
          end
          default: state_next_s = ST_TRAP;
        endcase
      end
      ST_MEM: begin
        dmem_req_s = 1'b1;
        dmem_we_s  = (cls_s == OPC_STORE);
        if (mem.dmem_ready) begin
          if (cls_s == OPC_STORE) begin
            pc_we        = 1'b1;
            retire_s     = 1'b1;
            state_next_s = ST_FETCH;
          end else begin
            state_next_s = ST_WB;
          end
        end else if (expired_s) begin
          timeout_s    = 1'b1;
          state_next_s = ST_TRAP;
        end else begin
          state_next_s = ST_MEM;
        end
      end
      ST_WB: begin
        reg_we       = (rd != 5'd0);
        wb_sel       = (cls_s == OPC_LOAD);
        pc_we        = 1'b1;
        retire_s     = 1'b1;
        state_next_s = ST_FETCH;
      end
      ST_TRAP: state_next_s = ST_TRAP;
      default: state_next_s = ST_TRAP;
    endcase
  end

  // State register plus sticky trap flags and the retired-instruction counter.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r   <= ST_FETCH;
      halt_r    <= 1'b0;
      bus_err_r <= 1'b0;
      retired_r <= {CNT_W{1'b0}};
    end else begin
      state_r   <= state_next_s;
      halt_r    <= (state_next_s == ST_TRAP);
      bus_err_r <= bus_err_r | timeout_s;
      retired_r <= retire_s ? (retired_r + CNT_W'(1)) : retired_r;
    end
  end

  assign mem.imem_req = imem_req_s;
  assign mem.dmem_req = dmem_req_s;
  assign mem.dmem_we  = dmem_we_s;
  assign halt         = halt_r;
  assign bus_err      = bus_err_r;
  assign retired      = retired_r;
endmodule
